// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the two multiply requesters and the shared
// multiplier arbiter; master = requester side, slave = arbiter side.
interface mul_share_arbiter_if #(
  parameter int DWidth = 32
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [1:0]        req0_op_i;
  logic [DWidth-1:0] req0_a_i;
  logic [DWidth-1:0] req0_b_i;
  logic              rsp0_valid_o;
  logic [DWidth-1:0] rsp0_res_o;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [1:0]        req1_op_i;
  logic [DWidth-1:0] req1_a_i;
  logic [DWidth-1:0] req1_b_i;
  logic              rsp1_valid_o;
  logic [DWidth-1:0] rsp1_res_o;
  logic              busy_o;

  modport master (
    output req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    output req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_res_o,
    input  req1_ready_o, rsp1_valid_o, rsp1_res_o,
    input  busy_o
  );

  modport slave (
    input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i,
    input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i,
    output req0_ready_o, rsp0_valid_o, rsp0_res_o,
    output req1_ready_o, rsp1_valid_o, rsp1_res_o,
    output busy_o
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one pipelined RV32M multiplier between two requesters.
// Optional grant counters: define MUL_SHARE_STATS_EN.
module mul_share_arbiter #(
  parameter int DWidth = 32,
  parameter int Lat    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mul_share_arbiter_if.slave  bus
`ifdef MUL_SHARE_STATS_EN
  ,
  input  logic                stats_clr_i,
  output logic [31:0]         grant0_cnt_o,
  output logic [31:0]         grant1_cnt_o
`endif
);

  localparam int Dly = (Lat > 2) ? Lat - 2 : 0;

  typedef enum logic {PRI0, PRI1} pri_e;

  // Sign-extend per operand signedness, multiply, pick the requested half.
  function automatic logic [DWidth-1:0] mul_sel(
    input logic [DWidth-1:0] a,
    input logic [DWidth-1:0] b,
    input logic              sa,
    input logic              sb,
    input logic              hi
  );
    logic signed [2*DWidth-1:0] ax;
    logic signed [2*DWidth-1:0] bx;
    logic signed [2*DWidth-1:0] p;
    ax = {{DWidth{sa & a[DWidth-1]}}, a};
    bx = {{DWidth{sb & b[DWidth-1]}}, b};
    p  = ax * bx;
    return hi ? p[2*DWidth-1:DWidth] : p[DWidth-1:0];
  endfunction

  pri_e              ptr;
  logic              grant0, grant1, accept;
  logic [1:0]        op_p0;
  logic [DWidth-1:0] a_p0, b_p0;
  logic              sa_p0, sb_p0, hi_p0;

  assign grant0 = bus.req0_valid_i & (~bus.req1_valid_i | (ptr == PRI0));
  assign grant1 = bus.req1_valid_i & (~bus.req0_valid_i | (ptr == PRI1));
  assign accept = grant0 | grant1;
  assign bus.req0_ready_o = grant0;
  assign bus.req1_ready_o = grant1;

  always_comb begin
    op_p0 = grant1 ? bus.req1_op_i : bus.req0_op_i;
    a_p0  = grant1 ? bus.req1_a_i  : bus.req0_a_i;
    b_p0  = grant1 ? bus.req1_b_i  : bus.req0_b_i;
    sa_p0 = (op_p0 != 2'b11);
    sb_p0 = ~op_p0[1];
    hi_p0 = (op_p0 != 2'b00);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       ptr <= PRI0;
    else if (grant0) ptr <= PRI1;
    else if (grant1) ptr <= PRI0;
  end

  // ---- stage 1: operand capture (product formed on its output) ----
  logic              head_vld, head_src, s1_vld;
  logic [DWidth-1:0] head_res;

  generate
    if (Lat == 1) begin : g_lat1
      assign s1_vld   = 1'b0;
      assign head_vld = accept;
      assign head_src = grant1;
      assign head_res = mul_sel(a_p0, b_p0, sa_p0, sb_p0, hi_p0);
    end else begin : g_stage1
      logic              vld_p1, src_p1, sa_p1, sb_p1, hi_p1;
      logic [DWidth-1:0] a_p1, b_p1;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) vld_p1 <= 1'b0;
        else       vld_p1 <= accept;
      end

      always_ff @(posedge clk_i) begin
        if (accept) begin
          src_p1 <= grant1;
          a_p1   <= a_p0;
          b_p1   <= b_p0;
          sa_p1  <= sa_p0;
          sb_p1  <= sb_p0;
          hi_p1  <= hi_p0;
        end
      end

      assign s1_vld   = vld_p1;
      assign head_vld = vld_p1;
      assign head_src = src_p1;
      assign head_res = mul_sel(a_p1, b_p1, sa_p1, sb_p1, hi_p1);
    end
  endgenerate

  // ---- stages 2..Lat-1: result delay for deeper pipelines ----
  logic              tail_vld, tail_src, dly_busy;
  logic [DWidth-1:0] tail_res;

  generate
    if (Dly == 0) begin : g_nodly
      assign tail_vld = head_vld;
      assign tail_src = head_src;
      assign tail_res = head_res;
      assign dly_busy = 1'b0;
    end else begin : g_dly
      logic              vld_q [0:Dly-1];
      logic              src_q [0:Dly-1];
      logic [DWidth-1:0] res_q [0:Dly-1];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int k = 0; k < Dly; k++) vld_q[k] <= 1'b0;
        end else begin
          vld_q[0] <= head_vld;
          for (int k = 1; k < Dly; k++) vld_q[k] <= vld_q[k-1];
        end
      end

      always_ff @(posedge clk_i) begin
        src_q[0] <= head_src;
        res_q[0] <= head_res;
        for (int k = 1; k < Dly; k++) begin
          src_q[k] <= src_q[k-1];
          res_q[k] <= res_q[k-1];
        end
      end

      always_comb begin
        dly_busy = 1'b0;
        for (int k = 0; k < Dly; k++) dly_busy = dly_busy | vld_q[k];
      end

      assign tail_vld = vld_q[Dly-1];
      assign tail_src = src_q[Dly-1];
      assign tail_res = res_q[Dly-1];
    end
  endgenerate

  // ---- stage Lat: per-port response registers, result held between pulses ----
  logic              rsp0_vld_q, rsp1_vld_q;
  logic [DWidth-1:0] rsp0_res_q, rsp1_res_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      rsp0_res_q <= '0;
      rsp1_res_q <= '0;
    end else begin
      rsp0_vld_q <= tail_vld & ~tail_src;
      rsp1_vld_q <= tail_vld &  tail_src;
      if (tail_vld & ~tail_src) rsp0_res_q <= tail_res;
      if (tail_vld &  tail_src) rsp1_res_q <= tail_res;
    end
  end

  assign bus.rsp0_valid_o = rsp0_vld_q;
  assign bus.rsp1_valid_o = rsp1_vld_q;
  assign bus.rsp0_res_o   = rsp0_res_q;
  assign bus.rsp1_res_o   = rsp1_res_q;
  assign bus.busy_o       = s1_vld | dly_busy | rsp0_vld_q | rsp1_vld_q;

`ifdef MUL_SHARE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant0_cnt_o <= '0;
      grant1_cnt_o <= '0;
    end else if (stats_clr_i) begin
      grant0_cnt_o <= '0;
      grant1_cnt_o <= '0;
    end else begin
      if (grant0) grant0_cnt_o <= grant0_cnt_o + 32'd1;
      if (grant1) grant1_cnt_o <= grant1_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: queue-based reference model checked every
// cycle, plus literal expectations. Define MUL_SHARE_STATS_EN to cover the counters.
module tb_mul_share_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.DWidth(32)) bus ();

`ifdef MUL_SHARE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] cnt0, cnt1;
`endif

  mul_share_arbiter #(.DWidth(32), .Lat(LAT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef MUL_SHARE_STATS_EN
    ,
    .stats_clr_i  (stats_clr),
    .grant0_cnt_o (cnt0),
    .grant1_cnt_o (cnt1)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product straight from the RV32M definitions.
  function automatic logic [31:0] model_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint x, y, p;
    x = (op == 2'b11) ? longint'({32'h0, a}) : longint'(signed'(a));
    y = op[1]         ? longint'({32'h0, b}) : longint'(signed'(b));
    p = x * y;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  typedef struct {
    int          due;
    bit          port;
    logic [31:0] res;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  bit          m_ptr;
  logic [31:0] last0, last1;
  logic [31:0] r0log[$], r1log[$];
  bit          glog[$];
`ifdef MUL_SHARE_STATS_EN
  logic [31:0] m_cnt0, m_cnt1;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and per-cycle comparison.
  always @(negedge clk) begin
    bit e0, e1, g0, g1;
    if (rst) begin
      q.delete();
      m_ptr = 0;
      last0 = '0;
      last1 = '0;
      chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
      chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid_o}, 32'd0);
      chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid_o}, 32'd0);
      chk("rst_rsp0_res", bus.rsp0_res_o, 32'd0);
      chk("rst_rsp1_res", bus.rsp1_res_o, 32'd0);
`ifdef MUL_SHARE_STATS_EN
      m_cnt0 = '0;
      m_cnt1 = '0;
      chk("rst_cnt0", cnt0, 32'd0);
      chk("rst_cnt1", cnt1, 32'd0);
`endif
    end else begin
      e0 = 0;
      e1 = 0;
      chk("busy", {31'b0, bus.busy_o}, {31'b0, q.size() > 0});
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].port) begin e1 = 1; last1 = q[0].res; end
        else           begin e0 = 1; last0 = q[0].res; end
        void'(q.pop_front());
      end
      chk("rsp0_valid", {31'b0, bus.rsp0_valid_o}, {31'b0, e0});
      chk("rsp1_valid", {31'b0, bus.rsp1_valid_o}, {31'b0, e1});
      chk("rsp0_res", bus.rsp0_res_o, last0);
      chk("rsp1_res", bus.rsp1_res_o, last1);
      if (bus.rsp0_valid_o) r0log.push_back(bus.rsp0_res_o);
      if (bus.rsp1_valid_o) r1log.push_back(bus.rsp1_res_o);

      g0 = bus.req0_valid_i && (!bus.req1_valid_i || !m_ptr);
      g1 = bus.req1_valid_i && (!bus.req0_valid_i ||  m_ptr);
      chk("ready0", {31'b0, bus.req0_ready_o}, {31'b0, g0});
      chk("ready1", {31'b0, bus.req1_ready_o}, {31'b0, g1});
      if (bus.req0_ready_o) glog.push_back(1'b0);
      if (bus.req1_ready_o) glog.push_back(1'b1);
`ifdef MUL_SHARE_STATS_EN
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
      if (stats_clr) begin
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else begin
        if (g0) m_cnt0 = m_cnt0 + 1;
        if (g1) m_cnt1 = m_cnt1 + 1;
      end
`endif
      if (g0) begin
        q.push_back('{cyc + LAT, 1'b0, model_mul(bus.req0_op_i, bus.req0_a_i, bus.req0_b_i)});
        m_ptr = 1;
      end else if (g1) begin
        q.push_back('{cyc + LAT, 1'b1, model_mul(bus.req1_op_i, bus.req1_a_i, bus.req1_b_i)});
        m_ptr = 0;
      end
    end
  end

  // Operand tables walked by the drive task (one entry consumed per grant).
  logic [1:0]  t0_op [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] t0_a  [6] = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                             32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000003};
  logic [31:0] t0_b  [6] = '{32'h00000002, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'hCAFEF00D, 32'hFFFFFFFF, 32'hFFFFFFFE};
  logic [1:0]  t1_op [6] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] t1_a  [6] = '{32'h00010000, 32'h12345678, 32'h80000000,
                             32'h80000000, 32'h00000000, 32'h0000FFFF};
  logic [31:0] t1_b  [6] = '{32'h00010000, 32'h9ABCDEF0, 32'h80000000,
                             32'h80000000, 32'hFFFFFFFF, 32'h00010001};
  int c0 = 0;
  int c1 = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load0();
    bus.req0_op_i = t0_op[c0 % 6];
    bus.req0_a_i  = t0_a[c0 % 6];
    bus.req0_b_i  = t0_b[c0 % 6];
  endtask

  task automatic load1();
    bus.req1_op_i = t1_op[c1 % 6];
    bus.req1_a_i  = t1_a[c1 % 6];
    bus.req1_b_i  = t1_b[c1 % 6];
  endtask

  // Hold the enabled valids for n cycles; operands advance only after a transfer.
  task automatic drive(input int n, input bit en0, input bit en1);
    bit g0, g1;
    load0();
    load1();
    bus.req0_valid_i = en0;
    bus.req1_valid_i = en1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      g0 = bus.req0_ready_o;
      g1 = bus.req1_ready_o;
      step();
      if (g0 && en0) begin c0++; load0(); end
      if (g1 && en1) begin c1++; load1(); end
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  task automatic issue(input bit port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (port) begin
      bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req0_valid_i = 1'b0; bus.req0_op_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_op_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // MUL -3 * 7 on port 0; response exactly LAT cycles later.
    issue(1'b0, 2'b00, 32'hFFFFFFFD, 32'h00000007);
    repeat (LAT - 1) step();
    @(negedge clk);
    chk("mul_neg_valid", {31'b0, bus.rsp0_valid_o}, 32'd1);
    chk("mul_neg_res", bus.rsp0_res_o, 32'hFFFFFFEB);
    chk("mul_neg_port1_quiet", {31'b0, bus.rsp1_valid_o}, 32'd0);
    step();

    // High-half variants back to back on port 1.
    r1log.delete();
    issue(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(1'b1, 2'b10, 32'hFFFFFFFF, 32'h00000002);
    repeat (LAT + 1) step();
    chk("hi_count", r1log.size(), 32'd3);
    chk("mulhu_res",  (r1log.size() > 0) ? r1log[0] : 'x, 32'hFFFFFFFE);
    chk("mulh_res",   (r1log.size() > 1) ? r1log[1] : 'x, 32'h00000000);
    chk("mulhsu_res", (r1log.size() > 2) ? r1log[2] : 'x, 32'hFFFFFFFF);

    // Both requesters valid for 6 cycles: strict alternation starting with port 0.
    glog.delete(); r0log.delete(); r1log.delete();
    c0 = 0; c1 = 0;
    drive(6, 1'b1, 1'b1);
    repeat (LAT + 1) step();
    chk("alt_grants", glog.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt_grant%0d", i), (glog.size() > i) ? {31'b0, glog[i]} : 'x, i % 2);
    chk("alt_rsp0_count", r0log.size(), 32'd3);
    chk("alt_rsp1_count", r1log.size(), 32'd3);
    chk("mul_wrap_res", (r0log.size() > 0) ? r0log[0] : 'x, 32'h00000000);
    chk("mulhu_2p32_res", (r1log.size() > 0) ? r1log[0] : 'x, 32'h00000001);

    // Port 1 alone for 3 cycles, then both: port 0 wins the first contested cycle.
    glog.delete();
    drive(3, 1'b0, 1'b1);
    drive(2, 1'b1, 1'b1);
    repeat (LAT + 1) step();
    chk("solo_grants", glog.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("solo_grant%0d", i), (glog.size() > i) ? {31'b0, glog[i]} : 'x,
          (i == 3) ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("drained_busy", {31'b0, bus.busy_o}, 32'd0);
    step();

    // Two ops in flight, then a one-cycle reset kills both and re-arms PRI0.
    drive(1, 1'b0, 1'b1);
    drive(1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r0log.delete(); r1log.delete();
    repeat (LAT + 1) step();
    chk("post_rst_rsp", r0log.size() + r1log.size(), 32'd0);
    @(negedge clk);
    chk("post_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    step();
    glog.delete();
    drive(1, 1'b1, 1'b1);
    chk("post_rst_grant", (glog.size() > 0) ? {31'b0, glog[0]} : 'x, 32'd0);
    repeat (LAT + 1) step();

`ifdef MUL_SHARE_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    drive(5, 1'b1, 1'b0);
    drive(3, 1'b0, 1'b1);
    @(negedge clk);
    chk("stats_cnt0", cnt0, 32'd5);
    chk("stats_cnt1", cnt1, 32'd3);
    step();
    stats_clr = 1'b1;
    drive(1, 1'b1, 1'b0);
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr_cnt0", cnt0, 32'd0);
    chk("stats_clr_cnt1", cnt1, 32'd0);
    step();
    repeat (LAT + 1) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
